cipher_cfg_loader: RTL and testbench

CIPHER_CFG_LOADER -- requirements
Module: cipher_cfg_loader

---
 rtl/cipher_cfg_pkg.sv | 27 ++
 rtl/cfg_bit_counter.sv | 36 +++
 rtl/cipher_cfg_loader.sv | 138 +++++++++++++
 tb/tb_cipher_cfg_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cipher_cfg_pkg
// Purpose : Shared widths, configuration-word field offsets and FSM states
//           for the cipher configuration chain loader.
// Rev     : 1.0
// ============================================================================
package cipher_cfg_pkg;

  localparam int CFG_W     = 131;
  localparam int LFSR_W    = 64;
  localparam int IDX_W     = 8;

  localparam int K_MUX_BIT = 130;
  localparam int A_MUX_BIT = 129;
  localparam int D_EN_BIT  = 128;
  localparam int TAPS_LSB  = 64;
  localparam int SEED_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : cipher_cfg_pkg
`default_nettype wire

// File: rtl/cfg_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : cfg_bit_counter
// Purpose : Shift index for the configuration loader; saturates at LAST and
//           flags the terminal count.
// Rev     : 1.0
// ============================================================================
module cfg_bit_counter #(
  parameter int IDX_W = 8,
  parameter int LAST  = 130
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(LAST);

  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx <= '0;
    end else if (i_en && (r_idx != C_LAST)) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == C_LAST);

endmodule : cfg_bit_counter
`default_nettype wire

// File: rtl/cipher_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : cipher_cfg_loader
// Purpose : Serialises {k_mux, a_mux, d_en, taps, seed} LSB first into a
//           downstream configuration chain. Optional readback of the previous
//           chain contents is enabled by macro CIPHER_CFG_READBACK_EN.
// Rev     : 1.0
// ============================================================================
module cipher_cfg_loader #(
  parameter int CFG_W  = cipher_cfg_pkg::CFG_W,
  parameter int LFSR_W = cipher_cfg_pkg::LFSR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              k_mux,
  input  logic              a_mux,
  input  logic              d_en,
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] seed,
  output logic              cfg_en,
  output logic              cfg_o,
  input  logic              cfg_i,
`ifdef CIPHER_CFG_READBACK_EN
  output logic [CFG_W-1:0]  rb_word,
  output logic              rb_valid,
`endif
  output logic              busy,
  output logic              done
);

  import cipher_cfg_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CFG_W-1:0]   r_word;
  logic [CFG_W-1:0]   w_word;
  logic [IDX_W-1:0]   w_idx;
  logic               w_last;
  logic               w_accept;
  logic               w_cnt_en;
  logic               w_shift;
  logic               w_done;

  always_comb begin
    w_word                          = '0;
    w_word[SEED_LSB +: LFSR_W]      = seed;
    w_word[TAPS_LSB +: LFSR_W]      = taps;
    w_word[D_EN_BIT]                = d_en;
    w_word[A_MUX_BIT]               = a_mux;
    w_word[K_MUX_BIT]               = k_mux;
  end

  cfg_bit_counter #(
    .IDX_W (IDX_W),
    .LAST  (CFG_W - 1)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (w_cnt_en),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_word <= w_word;
      end
    end
  end

  // Abort is tested before the terminal count so it wins at the last bit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cnt_en    = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_accept    = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cfg_en = w_shift;
  assign busy   = w_shift;
  assign done   = w_done;
  assign cfg_o  = w_shift ? r_word[w_idx] : 1'b0;

`ifdef CIPHER_CFG_READBACK_EN
  logic [CFG_W-1:0] r_rb_word;

  // Chain tail enters at the top, so after a full load bit 0 holds old chain bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rb_word <= '0;
    end else if (w_shift) begin
      r_rb_word <= {cfg_i, r_rb_word[CFG_W-1:1]};
    end
  end

  assign rb_word  = r_rb_word;
  assign rb_valid = w_done;
`else
  logic w_unused_cfg_i;
  assign w_unused_cfg_i = cfg_i;
`endif

endmodule : cipher_cfg_loader
`default_nettype wire

// File: tb/tb_cipher_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_cipher_cfg_loader
// Purpose : Randomised scoreboard bench for cipher_cfg_loader with a loopback
//           model of the downstream configuration chain.
// Rev     : 1.0
// ============================================================================
module tb_cipher_cfg_loader;

  import cipher_cfg_pkg::*;

  localparam int NB = CFG_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              k_mux;
  logic              a_mux;
  logic              d_en;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] seed;
  logic              cfg_i;
  logic              cfg_en;
  logic              cfg_o;
  logic              busy;
  logic              done;
`ifdef CIPHER_CFG_READBACK_EN
  logic [NB-1:0]     rb_word;
  logic              rb_valid;
`endif

  cipher_cfg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .k_mux    (k_mux),
    .a_mux    (a_mux),
    .d_en     (d_en),
    .taps     (taps),
    .seed     (seed),
    .cfg_en   (cfg_en),
    .cfg_o    (cfg_o),
    .cfg_i    (cfg_i),
`ifdef CIPHER_CFG_READBACK_EN
    .rb_word  (rb_word),
    .rb_valid (rb_valid),
`endif
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream chain: shifts towards bit 0 when enabled, tail feeds cfg_i.
  logic [NB-1:0] chain = '0;
  logic [NB-1:0] preload = '0;
  bit            chain_load = 1'b0;
  always @(posedge clk) begin
    if (chain_load)  chain <= preload;
    else if (cfg_en) chain <= {cfg_o, chain[NB-1:1]};
  end
  assign cfg_i = chain[0];

  typedef struct {int cyc; logic b;} bit_t;
  typedef struct {int cyc; logic rb_chk; logic [NB-1:0] rb;} done_t;
  bit_t  sq[$];
  done_t dq[$];

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] cur_word();
    return {k_mux, a_mux, d_en, taps, seed};
  endfunction

  // A load accepted at the edge that makes cyc==a streams bit i in cycle a+i
  // and pulses done in cycle a+NB, unless it is cut short.
  task automatic push_load(input int a, input logic [NB-1:0] w, input int nbits,
                           input bit has_done, input bit rbc, input logic [NB-1:0] rbexp);
    for (int i = 0; i < nbits; i++) sq.push_back('{a + i, w[i]});
    if (has_done) dq.push_back('{a + NB, rbc, rbexp});
  endtask

  task automatic randomize_inputs();
    k_mux = 1'($urandom_range(0, 1));
    a_mux = 1'($urandom_range(0, 1));
    d_en  = 1'($urandom_range(0, 1));
    taps  = {$urandom, $urandom};
    seed  = {$urandom, $urandom};
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue(input int nbits, input bit has_done, input bit rbc,
                       input logic [NB-1:0] rbexp, output int a);
    @(negedge clk);
    start = 1'b1;
    a = cyc + 1;
    push_load(a, cur_word(), nbits, has_done, rbc, rbexp);
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    logic act;
    logic dact;
    if (mon_on) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        chk1("stream_missed", 1'b0, 1'b1);
        void'(sq.pop_front());
      end
      act = (sq.size() > 0) && (sq[0].cyc == cyc);
      chk1("cfg_en", cfg_en, act);
      chk1("busy", busy, act);
      if (act) begin
        chk1("cfg_o", cfg_o, sq[0].b);
        void'(sq.pop_front());
      end else begin
        chk1("cfg_o_idle", cfg_o, 1'b0);
      end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        chk1("done_missed", 1'b0, 1'b1);
        void'(dq.pop_front());
      end
      dact = (dq.size() > 0) && (dq[0].cyc == cyc);
      chk1("done", done, dact);
`ifdef CIPHER_CFG_READBACK_EN
      chk1("rb_valid", rb_valid, dact);
      if (dact && dq[0].rb_chk) chkw("rb_word", rb_word, dq[0].rb);
`endif
      if (dact) void'(dq.pop_front());
    end
  end

  initial begin
    int a;
    int b;
    logic [135:0]  pat_wide;
    logic [NB-1:0] pattern;
    logic [NB-1:0] w1;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    k_mux = 1'b0; a_mux = 1'b0; d_en = 1'b0; taps = '0; seed = '0;
    repeat (3) @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk1("rst_cfg_en", cfg_en, 1'b0);
    chk1("rst_cfg_o", cfg_o, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    mon_on = 1'b1;

    // Directed load: taps=0x60, seed=0x55, control bits clear.
    taps = 64'h60; seed = 64'h55;
    issue(NB, 1'b1, 1'b0, '0, a);
    wait_until(a + NB + 2);

    // Random loads; inputs change mid-shift and must not leak in.
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      issue(NB, 1'b1, 1'b0, '0, a);
      wait_until(a + 10);
      randomize_inputs();
      wait_until(a + NB + 2);
    end

    // Start pulse at index 50 with different data is ignored.
    randomize_inputs();
    issue(NB, 1'b1, 1'b0, '0, a);
    wait_until(a + 50);
    randomize_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(a + NB + 2);

    // Abort at index 70.
    randomize_inputs();
    issue(71, 1'b0, 1'b0, '0, a);
    wait_until(a + 70);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(a + 75);

    // Abort on the last bit beats completion.
    randomize_inputs();
    issue(NB, 1'b0, 1'b0, '0, a);
    wait_until(a + NB - 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(a + NB + 3);

    // Abort while idle and during DONE has no effect.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    randomize_inputs();
    issue(NB, 1'b1, 1'b0, '0, a);
    wait_until(a + NB);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(a + NB + 2);

    // Reset at index 100, then a full load.
    randomize_inputs();
    issue(101, 1'b0, 1'b0, '0, a);
    wait_until(a + 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef CIPHER_CFG_READBACK_EN
    chkw("rst_rb_word", rb_word, '0);
`endif
    randomize_inputs();
    issue(NB, 1'b1, 1'b0, '0, a);
    wait_until(a + NB + 2);

    // Back-to-back with start held: DONE cycle plus one IDLE cycle between bursts.
    randomize_inputs();
    @(negedge clk);
    start = 1'b1;
    a = cyc + 1;
    push_load(a, cur_word(), NB, 1'b1, 1'b0, '0);
    wait_until(a);
    randomize_inputs();
    b = a + NB + 2;
    push_load(b, cur_word(), NB, 1'b1, 1'b0, '0);
    wait_until(b + 1);
    start = 1'b0;
    wait_until(b + NB + 2);

    // Readback: preload the chain, then two loads reading back the old contents.
    pat_wide = {17{8'h5A}};
    pattern  = pat_wide[NB-1:0];
    @(negedge clk);
    preload = pattern; chain_load = 1'b1;
    @(negedge clk);
    chain_load = 1'b0;
    randomize_inputs();
    w1 = cur_word();
    issue(NB, 1'b1, 1'b1, pattern, a);
    wait_until(a + NB + 2);
    randomize_inputs();
    issue(NB, 1'b1, 1'b1, w1, a);
    wait_until(a + NB + 2);

    repeat (5) @(negedge clk);
    chk1("stream_queue_empty", sq.size() == 0, 1'b1);
    chk1("done_queue_empty", dq.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cipher_cfg_loader
`default_nettype wire
